// File: rtl/prog_sequencer.sv
// Program load/run sequencer for the 8-bit accumulator processor: owns the instruction store,
// gates the processor clear/enable and captures one trace byte per executed cycle.
module prog_sequencer #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6,
   parameter int unsigned RUN_W = 16
) (
   input  logic             clk,
   input  logic             clb,
   input  logic             ld_valid,
   input  logic [7:0]       ld_data,
   input  logic             ld_last,
   output logic             ld_ready,
   input  logic             start,
   input  logic             halt_req,
   input  logic [RUN_W-1:0] run_len,
   input  logic [7:0]       cpu_pc,
   input  logic [7:0]       cpu_acc,
   output logic [7:0]       cpu_instr,
   output logic             cpu_clb,
   output logic             cpu_en,
   output logic             tr_valid,
   output logic [7:0]       tr_data,
   input  logic             tr_ready,
   output logic [1:0]       state,
   output logic             done,
   output logic             err_oob,
   output logic [RUN_W-1:0] cyc_count
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StLoad = 2'b01,
      StRun  = 2'b10,
      StDone = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [AW:0]      prog_len_q, prog_len_d;
   logic [AW-1:0]    wa_q, wa_d;
   logic             cpu_clb_q, cpu_clb_d;
   logic             cpu_en_q, cpu_en_d;
   logic             err_q, err_d;
   logic             halt_q, halt_d;
   logic             pend_q;
   logic [RUN_W-1:0] cyc_q, cyc_d;
   logic [RUN_W-1:0] len_q, len_d;
   logic [7:0]       mem [DEPTH];
   logic [7:0]       fifo_q [4];
   logic [1:0]       rd_q, wr_q;
   logic [2:0]       cnt_q;

   logic ld_acc, ld_end, start_ok, in_range, oob_now;
   logic budget_ok, budget_hit, room, flush, push, pop;

   assign in_range  = 9'(cpu_pc) < 9'(prog_len_q);
   assign cpu_instr = in_range ? mem[cpu_pc[AW-1:0]] : 8'h00;

   assign ld_ready = (state_q != StRun);
   assign ld_acc   = ld_valid & ld_ready;
   assign ld_end   = ld_acc & (ld_last | (wa_q == AW'(DEPTH - 1)));
   assign start_ok = start & ((state_q == StIdle) | (state_q == StDone)) &
                     (prog_len_q != '0) & ~ld_acc;

   // pc is only meaningful once the clear cycle has passed
   assign oob_now    = (state_q == StRun) & cpu_clb_q & ~in_range;
   assign budget_ok  = (len_q == '0) | (cyc_d < len_q);
   assign budget_hit = (len_q != '0) & (cyc_q >= len_q);
   // reserve a slot for every entry already in flight (pending push and current enable)
   assign room       = (4'(cnt_q) + 4'(pend_q) + 4'(cpu_en_q)) < 4'd4;
   assign push       = pend_q;
   assign pop        = tr_valid & tr_ready;

   always_comb begin
      state_d    = state_q;
      prog_len_d = prog_len_q;
      wa_d       = wa_q;
      err_d      = err_q;
      halt_d     = halt_q;
      len_d      = len_q;
      cyc_d      = cyc_q + RUN_W'(cpu_en_q);
      flush      = 1'b0;
      cpu_en_d   = 1'b0;
      if (ld_acc) begin
         wa_d    = wa_q + AW'(1);
         state_d = StLoad;
         if (ld_end) begin
            prog_len_d = (AW + 1)'(wa_q) + (AW + 1)'(1);
            wa_d       = '0;
            state_d    = StIdle;
         end
      end
      unique case (state_q)
         StIdle, StDone: begin
            if (start_ok) begin
               state_d = StRun;
               flush   = 1'b1;
               len_d   = run_len;
               cyc_d   = '0;
               err_d   = 1'b0;
               halt_d  = 1'b0;
            end
         end
         StRun: begin
            if (halt_req) halt_d = 1'b1;
            if (oob_now) err_d = 1'b1;
            if (cpu_clb_q & ~cpu_en_q & ~pend_q & (budget_hit | halt_q | err_q)) begin
               state_d = StDone;
            end else begin
               cpu_en_d = room & budget_ok & ~halt_req & ~halt_q & ~oob_now & ~err_q;
            end
         end
         default: ;
      endcase
      cpu_clb_d = ((state_q == StRun) & (state_d == StRun)) | (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (clb) begin
         state_q    <= StIdle;
         prog_len_q <= '0;
         wa_q       <= '0;
         cpu_clb_q  <= 1'b0;
         cpu_en_q   <= 1'b0;
         err_q      <= 1'b0;
         halt_q     <= 1'b0;
         pend_q     <= 1'b0;
         cyc_q      <= '0;
         len_q      <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         prog_len_q <= prog_len_d;
         wa_q       <= wa_d;
         cpu_clb_q  <= cpu_clb_d;
         cpu_en_q   <= cpu_en_d;
         err_q      <= err_d;
         halt_q     <= halt_d;
         pend_q     <= cpu_en_q;
         cyc_q      <= cyc_d;
         len_q      <= len_d;
         if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) wr_q <= wr_q + 2'd1;
            if (pop) rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_q + 3'(push) - 3'(pop);
         end
      end
   end

   // storage arrays carry no reset
   always_ff @(posedge clk) begin
      if (!clb && ld_acc) mem[wa_q] <= ld_data;
      if (!clb && push && !flush) fifo_q[wr_q] <= cpu_acc;
   end

   assign state     = state_q;
   assign done      = (state_q == StDone);
   assign cpu_clb   = cpu_clb_q;
   assign cpu_en    = cpu_en_q;
   assign err_oob   = err_q;
   assign cyc_count = cyc_q;
   assign tr_valid  = (cnt_q != 3'd0);
   assign tr_data   = fifo_q[rd_q];

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: a toy accumulator processor (acc += instr, pc++)
// drives the fetch port; trace bytes are checked against running sums of the loaded program.
module tb_prog_sequencer;

   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int RUN_W = 16;

   logic             clk = 1'b0;
   logic             clb = 1'b1;
   logic             ld_valid = 1'b0;
   logic [7:0]       ld_data = 8'h00;
   logic             ld_last = 1'b0;
   logic             ld_ready;
   logic             start = 1'b0;
   logic             halt_req = 1'b0;
   logic [RUN_W-1:0] run_len = '0;
   logic [7:0]       cpu_pc;
   logic [7:0]       cpu_acc = 8'h00;
   logic [7:0]       cpu_instr;
   logic             cpu_clb;
   logic             cpu_en;
   logic             tr_valid;
   logic [7:0]       tr_data;
   logic             tr_ready = 1'b0;
   logic [1:0]       state;
   logic             done;
   logic             err_oob;
   logic [RUN_W-1:0] cyc_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] prog [DEPTH];
   int         prog_len_m = 0;
   logic [7:0] mdl_pc = 8'h00;
   logic       pc_ovr = 1'b0;
   logic [7:0] pc_ovr_val = 8'h00;
   int         en_total = 0;
   int         clr_total = 0;
   logic [7:0] got_q [$];

   assign cpu_pc = pc_ovr ? pc_ovr_val : mdl_pc;

   prog_sequencer #(.DEPTH(DEPTH), .AW(AW), .RUN_W(RUN_W)) dut (
      .clk(clk), .clb(clb), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .start(start), .halt_req(halt_req), .run_len(run_len),
      .cpu_pc(cpu_pc), .cpu_acc(cpu_acc), .cpu_instr(cpu_instr), .cpu_clb(cpu_clb),
      .cpu_en(cpu_en), .tr_valid(tr_valid), .tr_data(tr_data), .tr_ready(tr_ready),
      .state(state), .done(done), .err_oob(err_oob), .cyc_count(cyc_count)
   );

   always #5 clk = ~clk;

   // toy processor: clear is active-low, one step per enabled edge
   always @(posedge clk) begin
      if (!cpu_clb) begin
         mdl_pc  <= 8'h00;
         cpu_acc <= 8'h00;
      end else if (cpu_en) begin
         mdl_pc  <= mdl_pc + 8'd1;
         cpu_acc <= cpu_acc + cpu_instr;
      end
   end

   always @(negedge clk) begin
      if (cpu_en === 1'b1) en_total++;
      if (state === 2'b10 && cpu_clb === 1'b0) clr_total++;
      if (tr_valid === 1'b1 && tr_ready === 1'b1) got_q.push_back(tr_data);
   end

   // accumulator after k executed steps: step i fetches address i, 0x00 beyond the program
   function automatic logic [7:0] exp_acc(input int k);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < k; i++) if (i < prog_len_m) s = s + prog[i];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_prog(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = prog[i];
         ld_last  = with_last && (i == n - 1);
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      prog_len_m = n;
   endtask

   task automatic pulse_start(input logic [RUN_W-1:0] rl);
      run_len = rl;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic test_reset();
      clb = 1'b1;
      tick();
      tick();
      clb = 1'b0;
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL rst_state got %0d want 0", state); end
      n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ld_ready got %b want 1", ld_ready); end
      n_checks++; if ({cpu_clb, cpu_en, tr_valid, done, err_oob} !== 5'b0) begin
         n_errors++; $display("FAIL rst_flags got %b want 00000", {cpu_clb, cpu_en, tr_valid, done, err_oob});
      end
      n_checks++; if (cyc_count !== '0) begin n_errors++; $display("FAIL rst_cyc got %0d want 0", cyc_count); end
      pulse_start(16'd4);
      tick();
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL rst_empty_start got %0d want 0", state); end
   endtask

   task automatic test_load();
      for (int i = 0; i < 5; i++) prog[i] = 8'h10 + 8'(i);
      ld_valid = 1'b1;
      ld_data  = prog[0];
      tick();
      n_checks++; if (state !== 2'b01) begin n_errors++; $display("FAIL load_state got %0d want 1", state); end
      for (int i = 1; i < 5; i++) begin
         ld_data = prog[i];
         ld_last = (i == 4);
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      prog_len_m = 5;
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL load_end_state got %0d want 0", state); end
      pc_ovr = 1'b1;
      for (int p = 0; p < 8; p++) begin
         logic [7:0] want;
         pc_ovr_val = 8'(p);
         want = (p < 5) ? 8'h10 + 8'(p) : 8'h00;
         #1;
         n_checks++; if (cpu_instr !== want) begin
            n_errors++; $display("FAIL load_fetch pc=%0d got %h want %h", p, cpu_instr, want);
         end
      end
      pc_ovr = 1'b0;
   endtask

   task automatic test_bounded();
      int base_en, base_clr, base_got, n;
      logic [RUN_W-1:0] rl;
      for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
      load_prog(DEPTH, 1'b0);
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL auto_end_state got %0d want 0", state); end
      pc_ovr = 1'b1;
      pc_ovr_val = 8'd63; #1;
      n_checks++; if (cpu_instr !== prog[63]) begin n_errors++; $display("FAIL fetch63 got %h want %h", cpu_instr, prog[63]); end
      pc_ovr_val = 8'd64; #1;
      n_checks++; if (cpu_instr !== 8'h00) begin n_errors++; $display("FAIL fetch64 got %h want 00", cpu_instr); end
      pc_ovr = 1'b0;
      tr_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         rl = (r == 0) ? 16'd8 : 16'($urandom_range(1, 30));
         base_en = en_total; base_clr = clr_total; base_got = got_q.size();
         pulse_start(rl);
         n_checks++; if ({state, cpu_clb, cpu_en} !== 4'b1000) begin
            n_errors++; $display("FAIL run_t1 got %b want 1000", {state, cpu_clb, cpu_en});
         end
         tick();
         n_checks++; if ({cpu_clb, cpu_en, tr_valid} !== 3'b110) begin
            n_errors++; $display("FAIL run_t2 got %b want 110", {cpu_clb, cpu_en, tr_valid});
         end
         tick();
         n_checks++; if (tr_valid !== 1'b0) begin n_errors++; $display("FAIL tv_t3 got %b want 0", tr_valid); end
         tick();
         n_checks++; if (tr_valid !== 1'b1) begin n_errors++; $display("FAIL tv_t4 got %b want 1", tr_valid); end
         for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
         for (int i = 0; i < 20 && tr_valid !== 1'b0; i++) tick();
         n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL bnd_done got %b want 1", done); end
         n_checks++; if (cyc_count !== rl) begin n_errors++; $display("FAIL bnd_cyc got %0d want %0d", cyc_count, rl); end
         n_checks++; if (en_total - base_en !== int'(rl)) begin
            n_errors++; $display("FAIL bnd_en_cycles got %0d want %0d", en_total - base_en, rl);
         end
         n_checks++; if (clr_total - base_clr !== 1) begin
            n_errors++; $display("FAIL bnd_clr_cycles got %0d want 1", clr_total - base_clr);
         end
         n = got_q.size() - base_got;
         n_checks++; if (n !== int'(rl)) begin n_errors++; $display("FAIL bnd_trace_n got %0d want %0d", n, rl); end
         for (int k = 1; k <= n; k++) begin
            n_checks++; if (got_q[base_got + k - 1] !== exp_acc(k)) begin
               n_errors++; $display("FAIL bnd_trace[%0d] got %h want %h", k, got_q[base_got + k - 1], exp_acc(k));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int base_en, base_got, n;
      tr_ready = 1'b0;
      base_en = en_total; base_got = got_q.size();
      pulse_start(16'd0);
      repeat (20) tick();
      n_checks++; if (en_total - base_en !== 4) begin
         n_errors++; $display("FAIL bp_en_cycles got %0d want 4", en_total - base_en);
      end
      n_checks++; if ({state, cpu_en, tr_valid} !== 4'b1001) begin
         n_errors++; $display("FAIL bp_stalled got %b want 1001", {state, cpu_en, tr_valid});
      end
      tr_ready = 1'b1;
      for (int i = 0; i < 400 && done !== 1'b1; i++) tick();
      for (int i = 0; i < 20 && tr_valid !== 1'b0; i++) tick();
      n_checks++; if ({done, err_oob} !== 2'b11) begin
         n_errors++; $display("FAIL bp_oob_end got %b want 11", {done, err_oob});
      end
      n = got_q.size() - base_got;
      n_checks++; if (n !== int'(cyc_count) || n < DEPTH || n > DEPTH + 1) begin
         n_errors++; $display("FAIL bp_trace_n got %0d entries cyc %0d want 64..65 and equal", n, cyc_count);
      end
      for (int k = 1; k <= n; k++) begin
         n_checks++; if (got_q[base_got + k - 1] !== exp_acc(k)) begin
            n_errors++; $display("FAIL bp_trace[%0d] got %h want %h", k, got_q[base_got + k - 1], exp_acc(k));
         end
      end
   endtask

   task automatic test_oob();
      int base_got, n;
      for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
      load_prog(3, 1'b1);
      base_got = got_q.size();
      pulse_start(16'd0);
      for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
      for (int i = 0; i < 20 && tr_valid !== 1'b0; i++) tick();
      n_checks++; if ({state, err_oob, cpu_en} !== 4'b1110) begin
         n_errors++; $display("FAIL oob_end got %b want 1110", {state, err_oob, cpu_en});
      end
      n_checks++; if (cpu_instr !== 8'h00) begin n_errors++; $display("FAIL oob_instr got %h want 00", cpu_instr); end
      n = got_q.size() - base_got;
      n_checks++; if (n !== int'(cyc_count) || n < 3) begin
         n_errors++; $display("FAIL oob_trace_n got %0d cyc %0d want >=3 and equal", n, cyc_count);
      end
      for (int k = 1; k <= n; k++) begin
         n_checks++; if (got_q[base_got + k - 1] !== exp_acc(k)) begin
            n_errors++; $display("FAIL oob_trace[%0d] got %h want %h", k, got_q[base_got + k - 1], exp_acc(k));
         end
      end
   endtask

   task automatic test_halt();
      for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
      load_prog(DEPTH, 1'($urandom_range(0, 1)));
      tr_ready = 1'b1;
      pulse_start(16'd0);
      repeat (5) tick();
      n_checks++; if (cpu_en !== 1'b1) begin n_errors++; $display("FAIL halt_en5 got %b want 1", cpu_en); end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL halt_en_drop got %b want 0", cpu_en); end
      for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
      n_checks++; if (done !== 1'b1 || (cyc_count !== 16'd5 && cyc_count !== 16'd6)) begin
         n_errors++; $display("FAIL halt_stop done=%b cyc=%0d want done=1 cyc 5 or 6", done, cyc_count);
      end
      pulse_start(16'd0);
      n_checks++; if ({state, cpu_clb, cyc_count} !== {2'b10, 1'b0, 16'd0}) begin
         n_errors++; $display("FAIL rerun state=%0d clb=%b cyc=%0d want 2 0 0", state, cpu_clb, cyc_count);
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rerun_done got %b want 1", done); end
   endtask

   task automatic test_reset_midrun();
      tr_ready = 1'($urandom_range(0, 1));
      pulse_start(16'd0);
      repeat (3 + $urandom_range(0, 5)) tick();
      n_checks++; if ({state, ld_ready} !== 3'b100) begin
         n_errors++; $display("FAIL mid_run got %b want 100", {state, ld_ready});
      end
      clb = 1'b1;
      tick();
      clb = 1'b0;
      n_checks++; if ({state, ld_ready, cpu_clb, cpu_en, tr_valid, done, err_oob} !== 8'b00100000) begin
         n_errors++; $display("FAIL mid_rst got %b want 00100000",
                              {state, ld_ready, cpu_clb, cpu_en, tr_valid, done, err_oob});
      end
      n_checks++; if (cyc_count !== '0) begin n_errors++; $display("FAIL mid_rst_cyc got %0d want 0", cyc_count); end
      pc_ovr = 1'b1; pc_ovr_val = 8'd0; #1;
      n_checks++; if (cpu_instr !== 8'h00) begin n_errors++; $display("FAIL mid_rst_fetch got %h want 00", cpu_instr); end
      pc_ovr = 1'b0;
      pulse_start(16'd3);
      tick();
      n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL mid_rst_start got %0d want 0", state); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_bounded();
      test_backpressure();
      test_oob();
      test_halt();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
